// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MUL/DIVU/REMU sequencer that borrows the shared execute-stage ALU
// for one shift-add (MUL) or restoring-divide step per clock.
module alu_muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result
);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  divisor;
    logic [XLEN-1:0]  acc, mcand, mplier;
    logic [XLEN-1:0]  rem, quot;

    logic             accept;
    logic             is_div;
    logic             skip_run;
    logic [XLEN-1:0]  sh;
    logic             ge;

    assign accept   = start_valid && (state == S_IDLE);
    assign is_div   = (op == OP_DIVU) || (op == OP_REMU);
    // Reserved op and divide-by-zero finish without iterating.
    assign skip_run = (op == 2'b11) || (is_div && (src_b == '0));

    // Restoring-divide step; the 33-bit compare keeps rem's top bit that the shift drops.
    assign sh = {rem[XLEN-2:0], quot[XLEN-1]};
    assign ge = ({rem[XLEN-1], sh} >= {1'b0, divisor});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = skip_run ? S_DONE : S_RUN;
            S_RUN:  if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE: if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: ALU drive depends only on registered state.
    always_comb begin
        start_ready = (state == S_IDLE);
        res_valid   = (state == S_DONE);
        busy        = (state != S_IDLE);
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = 4'b0000;
        result      = '0;
        if (state == S_RUN) begin
            if (op_q == OP_MUL) begin
                alu_a    = acc;
                alu_b    = mcand;
                alu_ctrl = ALU_ADD;
            end else begin
                alu_a    = sh;
                alu_b    = divisor;
                alu_ctrl = ALU_SUB;
            end
        end
        if (state == S_DONE) begin
            case (op_q)
                OP_MUL:  result = acc;
                OP_DIVU: result = quot;
                OP_REMU: result = rem;
                default: result = '0;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            cnt     <= '0;
            divisor <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quot    <= '0;
        end else if (accept) begin
            op_q    <= op;
            cnt     <= '0;
            divisor <= src_b;
            acc     <= '0;
            mcand   <= src_a;
            mplier  <= src_b;
            rem     <= '0;
            quot    <= src_a;
            if (is_div && (src_b == '0)) begin
                quot <= '1;
                rem  <= src_a;
            end
        end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
            if (op_q == OP_MUL) begin
                if (mplier[0]) acc <= alu_result;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else begin
                rem  <= ge ? alu_result : sh;
                quot <= {quot[XLEN-2:0], ge};
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Scoreboard bench for alu_muldiv_sequencer: driver queues expected results and
// latencies, a negedge monitor pops and compares whenever res_valid rises.
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] result;
    logic        busy;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;

    alu_muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .src_a(src_a), .src_b(src_b),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result)
    );

    // Shared execute-stage ALU model
    assign alu_result = (alu_ctrl == 4'b0010) ? alu_a + alu_b :
                        (alu_ctrl == 4'b0110) ? alu_a - alu_b : 32'h0;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acyc;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   cyc = 0;
    int   nchk = 0;
    int   npass = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: pop on res_valid rise, then require the result to stay put.
    always @(negedge clk) begin
        if (res_valid && !prev_v) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                cur = sbq.pop_front();
                check({cur.nm, "_result"}, result, cur.res);
                check({cur.nm, "_latency"}, 32'(cyc - cur.acyc), 32'(cur.lat));
            end
        end else if (res_valid) begin
            check({cur.nm, "_hold"}, result, cur.res);
        end
        prev_v = res_valid;
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat, input bit push, input string nm);
        int t = 0;
        while (!start_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!start_ready) check({nm, "_accept_timeout"}, 32'd0, 32'd1);
        start_valid = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        if (push) sbq.push_back('{res: e, lat: lat, acyc: cyc, nm: nm});
        @(negedge clk);
        start_valid = 1'b0;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!res_valid) check({nm, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a, b, e;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{o: 2'b00, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, e: 32'h1,         lat: 33, nm: "mul_ff"});
        vecs.push_back('{o: 2'b00, a: 32'h8000_0000, b: 32'h2,         e: 32'h0,         lat: 33, nm: "mul_wrap"});
        vecs.push_back('{o: 2'b01, a: 32'd100,       b: 32'd7,         e: 32'd14,        lat: 33, nm: "divu_100_7"});
        vecs.push_back('{o: 2'b10, a: 32'd100,       b: 32'd7,         e: 32'd2,         lat: 33, nm: "remu_100_7"});
        vecs.push_back('{o: 2'b01, a: 32'hFFFF_FFFF, b: 32'h1,         e: 32'hFFFF_FFFF, lat: 33, nm: "divu_ff_1"});
        vecs.push_back('{o: 2'b10, a: 32'h8000_0001, b: 32'h8000_0000, e: 32'h1,         lat: 33, nm: "remu_wide"});
        vecs.push_back('{o: 2'b01, a: 32'd5,         b: 32'd0,         e: 32'hFFFF_FFFF, lat: 1,  nm: "divu_by0"});
        vecs.push_back('{o: 2'b10, a: 32'd5,         b: 32'd0,         e: 32'd5,         lat: 1,  nm: "remu_by0"});
        vecs.push_back('{o: 2'b11, a: 32'd9,         b: 32'd3,         e: 32'd0,         lat: 1,  nm: "op_rsvd"});

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_res_valid",   32'(res_valid),   32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_result",      result,           32'd0);
        check("rst_alu_ctrl",    32'(alu_ctrl),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 7*6 with first-step ALU drive and busy drop
        issue(2'b00, 32'd7, 32'd6, 32'd42, 33, 1'b1, "mul_7_6");
        check("mul_alu_ctrl", 32'(alu_ctrl), 32'h2);
        check("mul_alu_a", alu_a, 32'd0);
        check("mul_alu_b", alu_b, 32'd7);
        check("run_start_ready", 32'(start_ready), 32'd0);
        check("run_busy", 32'(busy), 32'd1);
        wait_done("mul_7_6");
        @(negedge clk);
        check("mul_busy_fall", 32'(busy), 32'd0);
        check("mul_ready_back", 32'(start_ready), 32'd1);

        // DIVU first step drives SUB of the shifted remainder
        issue(2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1, "divu_first");
        check("div_alu_ctrl", 32'(alu_ctrl), 32'h6);
        check("div_alu_a", alu_a, 32'd0);
        check("div_alu_b", alu_b, 32'd7);
        wait_done("divu_first");
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat, 1'b1, vecs[i].nm);
            wait_done(vecs[i].nm);
            @(negedge clk);
        end

        // Backpressure: result held, start ignored while DONE
        res_ready = 1'b0;
        issue(2'b00, 32'd3, 32'd4, 32'd12, 33, 1'b1, "bp_mul");
        wait_done("bp_mul");
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                start_valid = 1'b1;
                op = 2'b01;
                src_a = 32'd9;
                src_b = 32'd0;
            end else begin
                start_valid = 1'b0;
            end
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_start_ready", 32'(start_ready), 32'd0);
            @(negedge clk);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", 32'(start_ready), 32'd1);
        check("bp_idle_valid", 32'(res_valid), 32'd0);
        issue(2'b10, 32'd100, 32'd7, 32'd2, 33, 1'b1, "bp_next");
        wait_done("bp_next");
        @(negedge clk);

        // Asynchronous abort mid-RUN
        issue(2'b00, 32'd100, 32'd100, 32'd0, 0, 1'b0, "abort");
        repeat (11) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_start_ready", 32'(start_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd5, 32'd15, 33, 1'b1, "post_abort_mul");
        wait_done("post_abort_mul");
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
